// File: rtl/cpu_defs.sv
// Shared constants for the result-routing blocks.
// Channel count, select width and a constant-time CLOG2.
package cpu_defs;

  localparam int NCHAN = 4;
  localparam int SELW  = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel word FIFO with occupancy count.
// Head entry is always presented on rdata.
module chan_fifo
  import cpu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PONE = AW'(1);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Storage write; push is already held low while clr is high.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= wdata;
  end

  // Pointer and occupancy update; a push+pop pair leaves count as is.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + PONE;
      if (pop)  r_rptr <= r_rptr + PONE;
      case ({push, pop})
        2'b10:   r_count <= r_count + CONE;
        2'b01:   r_count <= r_count - CONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rptr];
  assign full  = (r_count == CMAX);
  assign empty = (r_count == '0);

endmodule

// File: rtl/demux4x32_buf.sv
// Routes one valid/ready word stream to four buffered channels.
// Only select decode, ready mux and output packing live here.
module demux4x32_buf
  import cpu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SELW-1:0]        in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NCHAN*WIDTH-1:0] out_data,
  output logic [NCHAN-1:0]       out_valid,
  input  logic [NCHAN-1:0]       out_ready,
  output logic                   busy
);

  logic [NCHAN-1:0] w_push;
  logic [NCHAN-1:0] w_pop;
  logic [NCHAN-1:0] w_full;
  logic [NCHAN-1:0] w_empty;
  logic [WIDTH-1:0] w_rdata [NCHAN];
  logic             w_ready;

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign busy      = |out_valid;

  // A full channel still accepts when its head leaves this cycle.
  assign w_ready  = ~clr & (~w_full[in_sel] | w_pop[in_sel]);
  assign in_ready = w_ready;

  // Steer a transfer to the selected channel only.
  always_comb begin
    w_push         = '0;
    w_push[in_sel] = in_valid & w_ready;
  end

  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (w_push[k]),
      .pop   (w_pop[k]),
      .wdata (in_data),
      .rdata (w_rdata[k]),
      .full  (w_full[k]),
      .empty (w_empty[k])
    );
  end

  // Pack heads into lanes, zeroing empty channels.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NCHAN; k++) begin
      out_data[k*WIDTH +: WIDTH] = w_empty[k] ? '0 : w_rdata[k];
    end
  end

endmodule
